// File: rtl/coax_rx.sv
`default_nettype none
// ============================================================================
// Module   : coax_rx
// Brief    : Manchester coax receiver: bit-timing recovery, start-sequence
//            detection, 12-bit frame deserialisation with parity/framing checks.
// Revision : 1.0
// ============================================================================
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       data_strobe,
    output logic       parity_error,
    output logic       error,
    output logic [1:0] error_code
);

    localparam int c_PW      = $clog2(CLOCKS_PER_BIT);
    localparam int c_HALF    = CLOCKS_PER_BIT / 2;
    localparam int c_QUARTER = CLOCKS_PER_BIT / 4;

    localparam logic [c_PW-1:0] c_WIN_LO   = c_PW'(c_HALF - c_QUARTER);
    localparam logic [c_PW-1:0] c_WIN_HI   = c_PW'(c_HALF + c_QUARTER);
    localparam logic [c_PW-1:0] c_MID_NEXT = c_PW'(c_HALF + 1);
    localparam logic [c_PW-1:0] c_MISS     = c_PW'(c_HALF + c_QUARTER + 1);
    localparam logic [c_PW-1:0] c_LAST     = c_PW'(CLOCKS_PER_BIT - 1);

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_LQ        = 4'd1;
    localparam logic [3:0] c_ST_CV_LOW    = 4'd2;
    localparam logic [3:0] c_ST_CV_HIGH   = 4'd3;
    localparam logic [3:0] c_ST_SYNC      = 4'd4;
    localparam logic [3:0] c_ST_DATA      = 4'd5;
    localparam logic [3:0] c_ST_PARITY    = 4'd6;
    localparam logic [3:0] c_ST_NEXT_SYNC = 4'd7;
    localparam logic [3:0] c_ST_END       = 4'd8;

    logic [1:0]      sync_q;
    logic            s_prev_q;
    logic [c_PW-1:0] phase_q, phase_d;
    logic            mid_seen_q, mid_seen_d;
    logic [3:0]      state_q, state_d;
    logic [2:0]      lq_q, lq_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic            par_q, par_d;
    logic [9:0]      shift_q, shift_d;
    logic            active_q, active_d;
    logic [9:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic            perr_q, perr_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;

    logic w_s, w_edge, w_in_win, w_mid, w_rise, w_fall, w_missing;

    assign w_s       = sync_q[1];
    assign w_edge    = w_s ^ s_prev_q;
    assign w_in_win  = (phase_q >= c_WIN_LO) && (phase_q <= c_WIN_HI);
    assign w_mid     = w_edge && w_in_win && !mid_seen_q;
    assign w_rise    = w_mid && w_s;
    assign w_fall    = w_mid && !w_s;
    assign w_missing = (phase_q == c_MISS) && !mid_seen_q;

    // Bit-timing tracker; in IDLE any rising edge is taken as a mid-bit edge.
    always_comb begin
        phase_d    = phase_q;
        mid_seen_d = mid_seen_q;
        if ((state_q == c_ST_IDLE) && w_edge && w_s) begin
            phase_d    = c_MID_NEXT;
            mid_seen_d = 1'b1;
        end else if (w_mid) begin
            phase_d    = c_MID_NEXT;
            mid_seen_d = 1'b1;
        end else if (phase_q == c_LAST) begin
            phase_d    = '0;
            mid_seen_d = 1'b0;
        end else begin
            phase_d    = phase_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        lq_d     = lq_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        shift_d  = shift_q;
        active_d = active_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        perr_d   = perr_q;
        err_d    = 1'b0;
        code_d   = code_q;

        case (state_q)
            c_ST_IDLE: begin
                if (w_edge && w_s) begin
                    state_d = c_ST_LQ;
                    lq_d    = 3'd1;
                end
            end
            c_ST_LQ: begin
                if (w_rise) begin
                    if (lq_q != 3'd7) lq_d = lq_q + 3'd1;
                end else if (w_fall) begin
                    state_d = c_ST_IDLE;
                end else if (w_missing) begin
                    state_d = (!w_s && (lq_q >= 3'd3)) ? c_ST_CV_LOW : c_ST_IDLE;
                end
            end
            c_ST_CV_LOW: begin
                if (w_rise) begin
                    state_d  = c_ST_CV_HIGH;
                    active_d = 1'b1;
                end else if (w_fall || w_missing) begin
                    err_d  = 1'b1;
                    code_d = 2'd2;
                end
            end
            c_ST_CV_HIGH: begin
                if (w_mid || (w_missing && !w_s)) begin
                    err_d  = 1'b1;
                    code_d = 2'd2;
                end else if (w_missing) begin
                    state_d = c_ST_SYNC;
                end
            end
            c_ST_SYNC, c_ST_NEXT_SYNC: begin
                if (w_rise) begin
                    state_d  = c_ST_DATA;
                    bitcnt_d = 4'd0;
                    par_d    = 1'b1;
                end else if (w_fall && (state_q == c_ST_NEXT_SYNC)) begin
                    state_d = c_ST_END;
                end else if (w_fall || w_missing) begin
                    err_d  = 1'b1;
                    code_d = 2'd2;
                end
            end
            c_ST_DATA: begin
                if (w_mid) begin
                    shift_d  = {shift_q[8:0], w_s};
                    bitcnt_d = bitcnt_q + 4'd1;
                    par_d    = par_q ^ w_s;
                    if (bitcnt_q == 4'd9) state_d = c_ST_PARITY;
                end else if (w_missing) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end
            end
            c_ST_PARITY: begin
                if (w_mid) begin
                    strobe_d = 1'b1;
                    data_d   = shift_q;
                    perr_d   = (w_s != par_q);
                    state_d  = c_ST_NEXT_SYNC;
                end else if (w_missing) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end
            end
            c_ST_END: begin
                if (w_mid || (w_missing && !w_s)) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end else if (w_missing) begin
                    state_d  = c_ST_IDLE;
                    active_d = 1'b0;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase

        // Any framing fault abandons the frame; the partial word is dropped.
        if (err_d) begin
            state_d  = c_ST_IDLE;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b00;
            s_prev_q   <= 1'b0;
            phase_q    <= '0;
            mid_seen_q <= 1'b0;
            state_q    <= c_ST_IDLE;
            lq_q       <= 3'd0;
            bitcnt_q   <= 4'd0;
            par_q      <= 1'b0;
            shift_q    <= 10'd0;
            active_q   <= 1'b0;
            data_q     <= 10'd0;
            strobe_q   <= 1'b0;
            perr_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            s_prev_q   <= w_s;
            phase_q    <= phase_d;
            mid_seen_q <= mid_seen_d;
            state_q    <= state_d;
            lq_q       <= lq_d;
            bitcnt_q   <= bitcnt_d;
            par_q      <= par_d;
            shift_q    <= shift_d;
            active_q   <= active_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            perr_q     <= perr_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign active       = active_q;
    assign data         = data_q;
    assign data_strobe  = strobe_q;
    assign parity_error = perr_q;
    assign error        = err_q;
    assign error_code   = code_q;

endmodule
`default_nettype wire

// File: doc/coax_rx.md
# coax_rx

Receive-side counterpart of the coax transmitter. It recovers bit timing from the Manchester-coded coax line and detects the start sequence (line quiesce, then code violation). It then deserializes each 12-bit frame (sync, 10 data bits MSB-first, even parity) into 10-bit words, and reports framing and parity faults. It sits between the line receiver comparator and the host FIFO / register logic.

## Interface
- CLOCKS_PER_BIT, 8, clk cycles per coax bit; must be a multiple of 4 and at least 8.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  line data, true polarity, asynchronous to clk.
- active  output  1  high from a valid code violation until end sequence or error.
- data  output  10  last received word; holds until next strobe.
- data_strobe  output  1  one-clk pulse, data valid.
- parity_error  output  1  qualified by data_strobe; 1 = received parity mismatched.
- error  output  1  one-clk pulse on framing fault.
- error_code  output  2  qualified by error: 1 = missing mid-bit transition, 2 = bad start/sync, 3 = bad end sequence.

## Operation
- rx is passed through a 2-flop synchronizer, giving s. Edge = s differs from its previous value.
- Phase counter runs 0..CPB-1 and wraps. HALF = CPB/2, QUARTER = CPB/4.
  - Mid-bit window: phase HALF-QUARTER..HALF+QUARTER inclusive.
  - An edge in the window with mid_seen=0 is a mid-bit edge: bit value = new level of s, phase := HALF+1 next cycle, mid_seen := 1.
  - Edges outside the window are boundary edges and are ignored. Edges in the window with mid_seen=1 are also ignored.
  - mid_seen clears when phase wraps to 0.
  - Missing event: phase == HALF+QUARTER+1 and mid_seen=0.
- States:
  - IDLE: on a rising edge, phase := HALF+1, lq_count := 1, go to LINE_QUIESCE. A falling edge is ignored.
  - LINE_QUIESCE:
    - Rising mid-bit edge: lq_count+1, saturating at 7.
    - Falling mid-bit edge: go to IDLE, no error.
    - Missing event with s=0 and lq_count>=3: go to CV_LOW.
    - Missing event otherwise: go to IDLE, no error.
  - CV_LOW: a rising mid-bit edge goes to CV_HIGH and asserts active. A falling mid-bit edge or missing event is error 2.
  - CV_HIGH: a missing event with s=1 goes to SYNC_BIT. Any mid-bit edge is error 2.
  - SYNC_BIT: a rising mid-bit edge goes to DATA with bit_count := 0, parity := 1. A falling mid-bit edge or missing event is error 2.
  - DATA: each mid-bit edge shifts the bit into the LSB (MSB received first), bit_count+1, and toggles parity on a 1. After the 10th bit go to PARITY_BIT. A missing event is error 1.
  - PARITY_BIT: on a mid-bit edge of value v:
    - Next cycle: data_strobe=1, data = shift register, parity_error = (v != parity).
    - Go to NEXT_SYNC.
    - A missing event is error 1.
  - NEXT_SYNC:
    - Rising mid-bit edge: this is the next word's sync; go to DATA with bit_count := 0, parity := 1.
    - Falling mid-bit edge: go to END.
    - Missing event: error 2.
  - END: a missing event with s=1 goes to IDLE and deasserts active, no error. A mid-bit edge, or a missing event with s=0, is error 3.
- Any error:
  - error pulse with error_code, registered.
  - State goes to IDLE and active deasserts in the same cycle as the error pulse.
  - A partial word is discarded with no strobe.
- A parity mismatch is not a framing error: reception continues.

## Timing
- Reset (async, reset_n=0):
  - State IDLE.
  - active, data_strobe, parity_error, error, error_code and data all 0.
  - Synchronizer flops set to 0.
- Latency:
  - data_strobe is high 3 clk after the clk edge that first samples the parity mid-bit transition on rx: 2 synchronizer stages plus 1 registered strobe.
  - active rises 3 clk after the CV2 rising transition is first sampled.
- Back-to-back words arrive every 12 bit times. data must be stable for at least 12*CPB-1 clk after each strobe.
- reset_n asserted mid-frame: immediate return to IDLE. No strobe or error is emitted, even on release.
- A mid-bit edge coincident with phase wrap is impossible by window construction. Edge and missing event in the same cycle cannot occur because they lie in disjoint phases.

## Test plan
- Coax transmitter (CPB=8) sends one word 10'h2A5 → exactly one data_strobe, data=10'h2A5, parity_error=0, active high during frame, then low after END, error never pulses.
- Two queued words 10'h001, 10'h3FF back-to-back → two strobes 96 clk apart, data 10'h001 then 10'h3FF, parity_error=0 both.
- Frame 10'h155 with parity bit inverted → strobe with data=10'h155, parity_error=1, reception of the following word unaffected.
- Line held high for 3 bit times mid-DATA (after 4 data bits) → error=1, error_code=1, no strobe, active=0 the same cycle.
- Only 2 quiesce bits before code violation → no active, no strobe, no error; 6 quiesce bits after → normal word received.
- reset_n pulsed low during bit 6 of a word → all outputs 0 immediately, no strobe; next full frame 10'h0F0 received correctly.
